sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised per-pixel sprite compositor. It sits between the game logic (N `player` instances) and `vga_driver`, and replaces the single hard-wired rectangle-and-colour mux with N sprites, priority resolution, a per-state palette and per-frame collision detection. Sprite positions, states and enables are snapshotted once per frame at the start of vertical blanking, so a sprite never tears mid-frame. The block also generates the one-pulse-per-frame `frame_tick` that the game logic uses as its update clock enable.

## Interface
Parameters:
- `N_SPRITES`, 2: number of sprites (1..8); index 0 has highest priority.
- `SPRITE_W`, 100: sprite width in pixels (1..639).
- `SPRITE_H`, 100: sprite height in pixels (1..479).
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.

Ports:
- `clk`  in  1: pixel clock, the same 25 MHz clock that drives `vga_driver`.
- `rst`  in  1: synchronous, active-high reset.
- `pixel_x`  in  10: column being requested (`next_x` from `vga_driver`).
- `pixel_y`  in  10: row being requested (`next_y` from `vga_driver`).
- `sprite_x`  in  10*N_SPRITES: packed top-left X coordinates; sprite i occupies bits [10i+9:10i].
- `sprite_y`  in  10*N_SPRITES: packed top-left Y coordinates.
- `sprite_state`  in  4*N_SPRITES: packed player state codes.
- `sprite_en`  in  N_SPRITES: per-sprite visible enable.
- `bg_color`  in  8: background colour, RRRGGGBB format.
- `color_out`  out  8: composited colour, RRRGGGBB format.
- `frame_tick`  out  1: one-cycle pulse at the start of vertical blanking.
- `hit_mask`  out  N_SPRITES: sprites that overlapped another enabled sprite during the previous frame.
- `collision`  out  1: OR-reduction of `hit_mask`.

## Operation
- **Frame detect:**
  - cond = (`pixel_x` == 0 && `pixel_y` == V_ACTIVE).
  - A registered copy of cond is kept; `frame_tick` goes high for exactly one cycle on the rising edge of cond.
  - If cond holds for several cycles, only one pulse is produced.
- **Shadow load:** On the same clock edge that raises `frame_tick`, the shadow registers load `sprite_x`, `sprite_y`, `sprite_state` and `sprite_en`. All compositing uses the shadow registers only. Input changes at any other time have no effect until the next tick.
- **Hit test:** Sprite i is hit when all of the following hold:
  - shadow en[i] = 1;
  - `pixel_x` >= sx[i] and `pixel_x` < sx[i]+SPRITE_W;
  - `pixel_y` >= sy[i] and `pixel_y` < sy[i]+SPRITE_H.
  - Sums are computed at 11 bits. There is no wrap-around: a sprite at sx = 1000 is never hit, and a sprite at sx = 600 is clipped at column 639.
- **Active gating:** A pixel is active when `pixel_x` < H_ACTIVE and `pixel_y` < V_ACTIVE.
  - Inactive pixels: output is 8'h00 and there is no collision accumulation.
- **Priority:** The lowest-index hit sprite wins. With no hit, the output is `bg_color`, sampled in the same cycle as the coordinates.
- **Palette** (state to colour):
  - 0 → E0, 1 → 0F, 2 → F0, 3 → 1F, 4 → FC, 5 → FF.
  - 6..15 → 00.
- **Collision accumulator:**
  - On an active pixel where two or more sprites are hit, acc |= hit vector.
  - On the `frame_tick` edge, `hit_mask` <= acc and acc <= 0 simultaneously. No active pixel can coincide with the tick.
  - `collision` is combinational: |`hit_mask`.

## Timing
- **Latency:** 2 cycles from `pixel_x`/`pixel_y`/`bg_color` to `color_out`.
  - Stage 1 registers the hit vector, active flag and bg_color.
  - Stage 2 registers the priority-selected palette output.
  - The integrator compensates for this with a 2-cycle sync delay.
- **`frame_tick` timing:** The pulse is registered. It is high in cycle t+1 when cond first becomes true in cycle t. The shadow registers show the new values from cycle t+1.
- **`hit_mask` timing:** Updates in cycle t+1 and is held for the whole frame.
- **Reset values:** all of the following are 0:
  - `color_out`, `frame_tick`, `hit_mask`, `collision`;
  - the accumulator, pipeline registers, all shadow registers (en = 0) and the cond history.
- **Reset mid-frame:** Everything clears. Sprites stay invisible until the first `frame_tick` after reset. `color_out` reflects background/blank 2 cycles after reset is released.

## Test plan
- **Single sprite:**
  - Stimulus: N = 2; sprite0 at (100,50), state 1, en = 1; sprite1 disabled; bg = 8'h03; generate tick, then scan.
  - Required: (100,50) → 0F; (199,149) → 0F; (200,50) → 03; (99,50) → 03; every output 2 cycles after its coordinate.
- **Priority and collision:**
  - Stimulus: sprite0 at (100,100) state 0; sprite1 at (150,150) state 5; full frame, then tick.
  - Required: (160,160) → E0; (210,210) → FF; `hit_mask` = 2'b11 and `collision` = 1 after the tick; a following frame with no overlap gives `hit_mask` = 0.
- **Shadowing:**
  - Stimulus: change sprite_x from 100 to 300 mid-frame at row 200.
  - Required: remaining rows still use 100; the new position appears only after the next `frame_tick`.
- **Tick uniqueness:**
  - Stimulus: hold (0,480) for 4 cycles.
  - Required: exactly one `frame_tick` pulse.
- **Clipping and inactive area:**
  - Stimulus: sprite0 at (600,440), state 4.
  - Required: (639,479) → FC; (640,479) → 00; (0,480) → 00; sprite at x = 1000 → never visible.
- **Reset:**
  - Stimulus: assert `rst` mid-frame with sprites visible.
  - Required: all outputs 0 next cycle; background only until the next tick.

Source files
------------

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-sprite priority compositor with per-frame shadowing, palette and collision mask
module sprite_compositor #(
    parameter int N_SPRITES = 2,
    parameter int SPRITE_W  = 100,
    parameter int SPRITE_H  = 100,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               pixel_x,
    input  logic [9:0]               pixel_y,
    input  logic [10*N_SPRITES-1:0]  sprite_x,
    input  logic [10*N_SPRITES-1:0]  sprite_y,
    input  logic [4*N_SPRITES-1:0]   sprite_state,
    input  logic [N_SPRITES-1:0]     sprite_en,
    input  logic [7:0]               bg_color,
    output logic [7:0]               color_out,
    output logic                     frame_tick,
    output logic [N_SPRITES-1:0]     hit_mask,
    output logic                     collision
);

    localparam logic [10:0] SW    = 11'(SPRITE_W);
    localparam logic [10:0] SH    = 11'(SPRITE_H);
    localparam logic [9:0]  H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);

    logic                    cond, cond_q, tick_edge, active;
    logic [10*N_SPRITES-1:0] sh_x, sh_y;
    logic [4*N_SPRITES-1:0]  sh_state;
    logic [N_SPRITES-1:0]    sh_en, hit, hit_q, acc;
    logic [3:0]              hit_cnt;
    logic                    active_q;
    logic [7:0]              bg_q, sel_color;
    logic [10:0]             px, py;

    function automatic logic [7:0] palette(input logic [3:0] s);
        case (s)
            4'd0:    palette = 8'hE0;
            4'd1:    palette = 8'h0F;
            4'd2:    palette = 8'hF0;
            4'd3:    palette = 8'h1F;
            4'd4:    palette = 8'hFC;
            4'd5:    palette = 8'hFF;
            default: palette = 8'h00;
        endcase
    endfunction

    assign cond      = (pixel_x == 10'd0) && (pixel_y == V_ACT);
    assign tick_edge = cond && !cond_q;
    assign active    = (pixel_x < H_ACT) && (pixel_y < V_ACT);
    assign px        = {1'b0, pixel_x};
    assign py        = {1'b0, pixel_y};
    assign collision = |hit_mask;

    // 11-bit bounds so a sprite near the edge clips instead of wrapping
    always_comb begin
        hit     = '0;
        hit_cnt = 4'd0;
        for (int i = 0; i < N_SPRITES; i++) begin
            hit[i] = sh_en[i]
                  && (px >= {1'b0, sh_x[10*i +: 10]}) && (px < {1'b0, sh_x[10*i +: 10]} + SW)
                  && (py >= {1'b0, sh_y[10*i +: 10]}) && (py < {1'b0, sh_y[10*i +: 10]} + SH);
            hit_cnt = hit_cnt + {3'd0, hit[i]};
        end
    end

    // Walk from lowest priority upward so index 0 overrides everyone
    always_comb begin
        sel_color = bg_q;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) sel_color = palette(sh_state[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cond_q     <= 1'b0;
            frame_tick <= 1'b0;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_state   <= '0;
            sh_en      <= '0;
            acc        <= '0;
            hit_mask   <= '0;
            hit_q      <= '0;
            active_q   <= 1'b0;
            bg_q       <= 8'h00;
            color_out  <= 8'h00;
        end else begin
            cond_q     <= cond;
            frame_tick <= tick_edge;
            if (tick_edge) begin
                sh_x     <= sprite_x;
                sh_y     <= sprite_y;
                sh_state <= sprite_state;
                sh_en    <= sprite_en;
                hit_mask <= acc;
                acc      <= '0;
            end else if (active && (hit_cnt >= 4'd2)) begin
                acc <= acc | hit;
            end
            hit_q     <= hit;
            active_q  <= active;
            bg_q      <= bg_color;
            color_out <= active_q ? sel_color : 8'h00;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed self-checking bench for sprite_compositor
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x, pixel_y;
    logic [19:0] sprite_x, sprite_y;
    logic [7:0]  sprite_state;
    logic [1:0]  sprite_en;
    logic [7:0]  bg_color;
    logic [7:0]  color_out;
    logic        frame_tick;
    logic [1:0]  hit_mask;
    logic        collision;

    int checks = 0;
    int errors = 0;

    sprite_compositor #(
        .N_SPRITES(2), .SPRITE_W(100), .SPRITE_H(100), .H_ACTIVE(640), .V_ACTIVE(480)
    ) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_state(sprite_state),
        .sprite_en(sprite_en), .bg_color(bg_color), .color_out(color_out),
        .frame_tick(frame_tick), .hit_mask(hit_mask), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input int st);
        sprite_x[10*i +: 10]   = 10'(x);
        sprite_y[10*i +: 10]   = 10'(y);
        sprite_state[4*i +: 4] = 4'(st);
    endtask

    task automatic do_tick();
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        step();
        pixel_x = 10'd1;
        step();
    endtask

    task automatic get_pix(input int x, input int y, output logic [7:0] c);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        step();
        step();
        c = color_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pixel_x = 10'd0; pixel_y = 10'd0;
        sprite_x = '0; sprite_y = '0; sprite_state = '0; sprite_en = '0;
        bg_color = 8'h03;
        step(); step(); step();
        checks++;
        if ({color_out, frame_tick, hit_mask, collision} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got color=%h tick=%b mask=%b coll=%b required all 0",
                     color_out, frame_tick, hit_mask, collision);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] c;
        int xs [4] = '{100, 199, 200, 99};
        int ys [4] = '{50, 149, 50, 50};
        logic [7:0] ex [4] = '{8'h0F, 8'h0F, 8'h03, 8'h03};
        set_sprite(0, 100, 50, 1);
        set_sprite(1, 300, 300, 2);
        sprite_en = 2'b01;
        bg_color = 8'h03;
        do_tick();
        for (int i = 0; i < 4; i++) begin
            get_pix(xs[i], ys[i], c);
            checks++;
            if (c !== ex[i]) begin
                errors++;
                $display("FAIL single_pix(%0d,%0d): got %h required %h", xs[i], ys[i], c, ex[i]);
            end
        end
        get_pix(310, 310, c);
        checks++;
        if (c !== 8'h03) begin
            errors++;
            $display("FAIL single_disabled: got %h required 03", c);
        end
    endtask

    task automatic test_back_to_back();
        int         xs [5] = '{99, 100, 199, 200, 150};
        logic [7:0] bg [5] = '{8'h1C, 8'h03, 8'hE3, 8'h1C, 8'hE3};
        logic [7:0] ex [5] = '{8'h1C, 8'h0F, 8'h0F, 8'h1C, 8'h0F};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                pixel_x  = 10'(xs[i]);
                pixel_y  = 10'd50;
                bg_color = bg[i];
            end
            step();
            if (i >= 1) begin
                checks++;
                if (color_out !== ex[i-1]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got %h required %h", i - 1, color_out, ex[i-1]);
                end
            end
        end
        bg_color = 8'h03;
    endtask

    task automatic test_priority();
        logic [7:0] c;
        set_sprite(0, 100, 100, 0);
        set_sprite(1, 150, 150, 5);
        sprite_en = 2'b11;
        do_tick();
        get_pix(160, 160, c);
        checks++;
        if (c !== 8'hE0) begin errors++; $display("FAIL prio_overlap: got %h required E0", c); end
        get_pix(210, 210, c);
        checks++;
        if (c !== 8'hFF) begin errors++; $display("FAIL prio_sprite1: got %h required FF", c); end
        do_tick();
        checks++;
        if (hit_mask !== 2'b11 || collision !== 1'b1) begin
            errors++;
            $display("FAIL collision_set: got mask=%b coll=%b required 11/1", hit_mask, collision);
        end
        get_pix(210, 210, c);
        get_pix(120, 120, c);
        do_tick();
        checks++;
        if (hit_mask !== 2'b00 || collision !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear: got mask=%b coll=%b required 00/0", hit_mask, collision);
        end
    endtask

    task automatic test_shadow();
        logic [7:0] c;
        set_sprite(0, 100, 150, 1);
        sprite_en = 2'b01;
        do_tick();
        get_pix(100, 200, c);
        checks++;
        if (c !== 8'h0F) begin errors++; $display("FAIL shadow_before: got %h required 0F", c); end
        sprite_x[9:0] = 10'd300;
        get_pix(100, 240, c);
        checks++;
        if (c !== 8'h0F) begin errors++; $display("FAIL shadow_old_pos: got %h required 0F", c); end
        get_pix(300, 240, c);
        checks++;
        if (c !== 8'h03) begin errors++; $display("FAIL shadow_new_early: got %h required 03", c); end
        do_tick();
        get_pix(300, 240, c);
        checks++;
        if (c !== 8'h0F) begin errors++; $display("FAIL shadow_new_pos: got %h required 0F", c); end
        get_pix(100, 240, c);
        checks++;
        if (c !== 8'h03) begin errors++; $display("FAIL shadow_old_gone: got %h required 03", c); end
    endtask

    task automatic test_tick();
        int pulses = 0;
        logic first;
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) first = frame_tick;
            if (frame_tick === 1'b1) pulses++;
        end
        pixel_x = 10'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            if (frame_tick === 1'b1) pulses++;
        end
        checks++;
        if (first !== 1'b1) begin errors++; $display("FAIL tick_timing: got %b required 1", first); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL tick_unique: got %0d pulses required 1", pulses); end
    endtask

    task automatic test_clip();
        logic [7:0] c;
        set_sprite(0, 600, 440, 4);
        set_sprite(1, 1000, 0, 5);
        sprite_en = 2'b11;
        do_tick();
        get_pix(639, 479, c);
        checks++;
        if (c !== 8'hFC) begin errors++; $display("FAIL clip_corner: got %h required FC", c); end
        get_pix(640, 479, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL clip_hblank: got %h required 00", c); end
        get_pix(0, 480, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL clip_vblank: got %h required 00", c); end
        get_pix(1010, 10, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL far_sprite_offscreen: got %h required 00", c); end
        get_pix(639, 10, c);
        checks++;
        if (c !== 8'h03) begin errors++; $display("FAIL far_sprite_no_wrap: got %h required 03", c); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] c;
        set_sprite(0, 600, 440, 4);
        set_sprite(1, 610, 450, 5);
        sprite_en = 2'b11;
        do_tick();
        get_pix(620, 460, c);
        do_tick();
        get_pix(620, 460, c);
        checks++;
        if (c !== 8'hFC || hit_mask !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset: got color=%h mask=%b required FC/11", c, hit_mask);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({color_out, frame_tick, hit_mask, collision} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got color=%h tick=%b mask=%b coll=%b required all 0",
                     color_out, frame_tick, hit_mask, collision);
        end
        rst = 1'b0;
        get_pix(620, 460, c);
        checks++;
        if (c !== 8'h03) begin errors++; $display("FAIL post_reset_bg: got %h required 03", c); end
        do_tick();
        get_pix(620, 460, c);
        checks++;
        if (c !== 8'hFC) begin errors++; $display("FAIL post_reset_tick: got %h required FC", c); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_priority();
        test_shadow();
        test_tick();
        test_clip();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
